// File: rtl/nn_resample_addr_gen.sv
// Nearest-neighbour resample address generator: streams FRAME_LEN source addresses
// addr(i) = i*ratio from a phase accumulator, with round/truncate, wrap/clamp and fraction output.
module nn_resample_addr_gen #(
    parameter int IDX_W      = 9,
    parameter int ADDR_W     = 11,
    parameter int RATIO_W    = 32,
    parameter int FRAC_W     = 19,
    parameter int FRAC_OUT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [RATIO_W-1:0]    ratio,
    input  logic                  round_en,
    input  logic                  wrap_en,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_index,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [FRAC_OUT_W-1:0] out_frac,
    output logic                  out_last,
    output logic                  done,
    output logic                  clipped
);

    localparam int ACC_W = IDX_W + RATIO_W;
    localparam int RAW_W = ACC_W - FRAC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [RATIO_W-1:0]    ratio_q;
    logic                  round_q;
    logic                  wrap_q;
    logic [ACC_W-1:0]      acc;

    logic                  accept;
    logic                  xfer;
    logic                  load;
    logic                  round_sel;
    logic                  wrap_sel;
    logic [ACC_W-1:0]      acc_n;
    logic [ACC_W:0]        acc_rnd;
    logic [RAW_W-1:0]      raw;
    logic                  oor;
    logic [IDX_W-1:0]      index_n;
    logic [ADDR_W-1:0]     addr_n;
    logic [FRAC_OUT_W-1:0] frac_n;

    assign accept = (state == S_IDLE) && start;
    assign xfer   = (state == S_RUN) && out_valid && out_ready;
    assign load   = accept || (xfer && !out_last);
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_RUN;
            S_RUN:   if (xfer && out_last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Next word is computed from the accumulator value it will present, so the
    // registered outputs always describe the word currently on the bus.
    always_comb begin
        round_sel = accept ? round_en : round_q;
        wrap_sel  = accept ? wrap_en : wrap_q;
        acc_n     = accept ? '0 : acc + ACC_W'(ratio_q);
        index_n   = accept ? '0 : out_index + IDX_W'(1);
        acc_rnd   = {1'b0, acc_n};
        if (round_sel) begin
            acc_rnd = acc_rnd + ((ACC_W + 1)'(1) << (FRAC_W - 1));
        end
        raw    = RAW_W'(acc_rnd >> FRAC_W);
        oor    = |raw[RAW_W-1:ADDR_W];
        addr_n = raw[ADDR_W-1:0];
        if (oor && !wrap_sel) begin
            addr_n = '1;
        end
        frac_n = acc_n[FRAC_W-1 -: FRAC_OUT_W];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ratio_q   <= '0;
            round_q   <= 1'b0;
            wrap_q    <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_addr  <= '0;
            out_frac  <= '0;
            out_last  <= 1'b0;
            clipped   <= 1'b0;
        end else begin
            if (accept) begin
                ratio_q <= ratio;
                round_q <= round_en;
                wrap_q  <= wrap_en;
            end
            if (load) begin
                acc       <= acc_n;
                out_valid <= 1'b1;
                out_index <= index_n;
                out_addr  <= addr_n;
                out_frac  <= frac_n;
                out_last  <= (index_n == '1);
                clipped   <= (accept ? 1'b0 : clipped) | oor;
            end else if (xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
